// File: rtl/coin_scan_controller.sv
`default_nettype none
// ============================================================================
// coin_scan_controller - time-multiplexed Mario/coin overlap scan, one coin
// per clock per frame; tracks collected coins, saturating score, sound requests
// Revision 1.0
// ============================================================================
module coin_scan_controller #(
  parameter int NUM_COINS       = 8,
  parameter int CHARACTER_WIDTH = 42,
  parameter int BLOCK_WIDTH     = 40,
  parameter int INSET           = 10,
  parameter int SCORE_WIDTH     = 16,
  parameter int COIN_VALUE      = 1,
  localparam int IW = (NUM_COINS > 1) ? $clog2(NUM_COINS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_start,
  input  logic                   level_clear,
  input  logic [15:0]            mario_x,
  input  logic [15:0]            mario_y,
  input  logic                   coin_wr_en,
  input  logic [IW-1:0]          coin_wr_idx,
  input  logic [7:0]             coin_wr_tx,
  input  logic [7:0]             coin_wr_ty,
  output logic [NUM_COINS-1:0]   collected,
  output logic [SCORE_WIDTH-1:0] score,
  output logic                   coin_event,
  output logic [IW-1:0]          event_idx,
  output logic                   scan_done,
  output logic                   busy,
  output logic                   sfx_req,
  input  logic                   sfx_ack
);

  localparam int PW = $clog2(NUM_COINS + 1);
  localparam logic [PW-1:0] PMAX = PW'(NUM_COINS);
  localparam logic [SCORE_WIDTH:0] SMAX = {1'b0, {SCORE_WIDTH{1'b1}}};
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_COINS - 1);
  localparam logic [16:0] C_LO = 17'(INSET);
  localparam logic [16:0] C_HI = 17'(CHARACTER_WIDTH - INSET);
  localparam logic [16:0] C_BW = 17'(BLOCK_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LATCH = 2'd1,
    S_SCAN  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state, w_next;

  logic [7:0]             r_tx [NUM_COINS];
  logic [7:0]             r_ty [NUM_COINS];
  logic [NUM_COINS-1:0]   r_valid, r_collected;
  logic [SCORE_WIDTH-1:0] r_score;
  logic                   r_coin_event, r_sfx_req;
  logic [IW-1:0]          r_event_idx, r_idx;
  logic [PW-1:0]          r_pend;
  logic [16:0]            r_l, r_r, r_t, r_b;

  logic                   w_last, w_hit, w_wr_ok, w_ack, w_tx_hit, w_ty_hit;
  logic [16:0]            w_cur_tx, w_cur_ty;
  logic [SCORE_WIDTH:0]   w_sum;
  logic [SCORE_WIDTH-1:0] w_score_next;
  logic [PW-1:0]          w_pend_next;

  // Width-extended compare keeps the out-of-range check meaningful for any NUM_COINS
  assign w_wr_ok  = coin_wr_en && (r_state == S_IDLE) &&
                    ({1'b0, coin_wr_idx} < (IW+1)'(NUM_COINS));
  assign w_last   = (r_idx == LAST_IDX);
  assign w_cur_tx = {9'd0, r_tx[r_idx]};
  assign w_cur_ty = {9'd0, r_ty[r_idx]};
  assign w_tx_hit = (w_cur_tx == r_l) || (w_cur_tx == r_r);
  assign w_ty_hit = (w_cur_ty == r_t) || (w_cur_ty == r_b);
  assign w_hit    = (r_state == S_SCAN) && r_valid[r_idx] && !r_collected[r_idx] &&
                    w_tx_hit && w_ty_hit;
  assign w_ack    = r_sfx_req && sfx_ack;

  assign w_sum        = {1'b0, r_score} + (SCORE_WIDTH+1)'(COIN_VALUE);
  assign w_score_next = (w_sum > SMAX) ? SMAX[SCORE_WIDTH-1:0] : w_sum[SCORE_WIDTH-1:0];

  always_comb begin
    w_pend_next = r_pend;
    if (w_hit && !w_ack) begin
      if (r_pend != PMAX) w_pend_next = r_pend + PW'(1);
    end else if (!w_hit && w_ack) begin
      w_pend_next = r_pend - PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (frame_start) w_next = S_LATCH;
      S_LATCH: w_next = S_SCAN;
      S_SCAN:  if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (level_clear) w_next = S_IDLE;
  end

  // Tile table carries no reset; r_valid gates every use of it
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_tx[coin_wr_idx] <= coin_wr_tx;
      r_ty[coin_wr_idx] <= coin_wr_ty;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid      <= '0;
      r_collected  <= '0;
      r_score      <= '0;
      r_coin_event <= 1'b0;
      r_event_idx  <= '0;
      r_pend       <= '0;
      r_sfx_req    <= 1'b0;
      r_idx        <= '0;
      r_l          <= '0;
      r_r          <= '0;
      r_t          <= '0;
      r_b          <= '0;
    end else begin
      r_coin_event <= 1'b0;
      if (w_wr_ok) r_valid[coin_wr_idx] <= 1'b1;
      if (level_clear) begin
        r_collected <= '0;
        r_score     <= '0;
        r_pend      <= '0;
        r_sfx_req   <= 1'b0;
      end else begin
        if (w_wr_ok) r_collected[coin_wr_idx] <= 1'b0;
        if (w_hit) begin
          r_collected[r_idx] <= 1'b1;
          r_score            <= w_score_next;
          r_coin_event       <= 1'b1;
          r_event_idx        <= r_idx;
        end
        r_pend    <= w_pend_next;
        r_sfx_req <= (w_pend_next != '0);
      end
      if (r_state == S_LATCH) begin
        r_l   <= ({1'b0, mario_x} + C_LO) / C_BW;
        r_r   <= ({1'b0, mario_x} + C_HI) / C_BW;
        r_t   <= ({1'b0, mario_y} + C_LO) / C_BW;
        r_b   <= ({1'b0, mario_y} + C_HI) / C_BW;
        r_idx <= '0;
      end else if (r_state == S_SCAN && !w_last) begin
        r_idx <= r_idx + IW'(1);
      end
    end
  end

  assign collected  = r_collected;
  assign score      = r_score;
  assign coin_event = r_coin_event;
  assign event_idx  = r_event_idx;
  assign scan_done  = (r_state == S_DONE);
  assign busy       = (r_state != S_IDLE);
  assign sfx_req    = r_sfx_req;

endmodule
`default_nettype wire

// File: tb/tb_coin_scan_controller.sv
`default_nettype none
// ============================================================================
// tb_coin_scan_controller - table-driven frames with an event scoreboard,
// plus hand-written sequences for sound handshake, busy, clear and reset
// Revision 1.0
// ============================================================================
module tb_coin_scan_controller;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        reset, frame_start, level_clear, coin_wr_en, sfx_ack;
  logic [15:0] mario_x, mario_y;
  logic [2:0]  coin_wr_idx;
  logic [7:0]  coin_wr_tx, coin_wr_ty;
  logic [7:0]  collected, collected2;
  logic [15:0] score;
  logic [1:0]  score2;
  logic        coin_event, scan_done, busy, sfx_req;
  logic        coin_event2, scan_done2, busy2, sfx_req2;
  logic [2:0]  event_idx, event_idx2;

  coin_scan_controller dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .level_clear(level_clear),
    .mario_x(mario_x), .mario_y(mario_y), .coin_wr_en(coin_wr_en),
    .coin_wr_idx(coin_wr_idx), .coin_wr_tx(coin_wr_tx), .coin_wr_ty(coin_wr_ty),
    .collected(collected), .score(score), .coin_event(coin_event),
    .event_idx(event_idx), .scan_done(scan_done), .busy(busy),
    .sfx_req(sfx_req), .sfx_ack(sfx_ack)
  );

  // Narrow-score copy sharing all stimulus, used to observe saturation
  coin_scan_controller #(.SCORE_WIDTH(2), .COIN_VALUE(1)) dut2 (
    .clk(clk), .reset(reset), .frame_start(frame_start), .level_clear(level_clear),
    .mario_x(mario_x), .mario_y(mario_y), .coin_wr_en(coin_wr_en),
    .coin_wr_idx(coin_wr_idx), .coin_wr_tx(coin_wr_tx), .coin_wr_ty(coin_wr_ty),
    .collected(collected2), .score(score2), .coin_event(coin_event2),
    .event_idx(event_idx2), .scan_done(scan_done2), .busy(busy2),
    .sfx_req(sfx_req2), .sfx_ack(sfx_ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ev_count = 0;
  bit mon_en = 1'b0;

  typedef struct { int idx; int cyc; } ev_t;
  ev_t q[$];
  ev_t e_mon;

  bit       mv   [N];
  bit       mcol [N];
  int       mtx  [N];
  int       mty  [N];

  typedef struct { int x; int y; logic [7:0] col; int score; int nev; } vec_t;
  vec_t vecs[6];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && coin_event) begin
      ev_count++;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: idx %0d at cycle %0d, expected none", event_idx, cyc);
      end else begin
        checks--;
        e_mon = q.pop_front();
        chk("event_idx", 32'(event_idx), 32'(e_mon.idx));
        chk("event_cycle", 32'(cyc), 32'(e_mon.cyc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int idx, input int tx, input int ty);
    coin_wr_en = 1'b1; coin_wr_idx = 3'(idx); coin_wr_tx = 8'(tx); coin_wr_ty = 8'(ty);
    tick();
    coin_wr_en = 1'b0;
    mv[idx] = 1'b1; mtx[idx] = tx; mty[idx] = ty; mcol[idx] = 1'b0;
  endtask

  task automatic do_frame(input int x, input int y);
    int t0, l, r, tp, b, n;
    mario_x = 16'(x); mario_y = 16'(y);
    l = (x + 10) / 40; r = (x + 32) / 40; tp = (y + 10) / 40; b = (y + 32) / 40;
    t0 = cyc;
    for (int i = 0; i < N; i++) begin
      if (mv[i] && !mcol[i] && (mtx[i] == l || mtx[i] == r) && (mty[i] == tp || mty[i] == b)) begin
        mcol[i] = 1'b1;
        q.push_back('{idx: i, cyc: t0 + 3 + i});
      end
    end
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    n = 0;
    while (!scan_done && n < N + 6) begin
      tick();
      n++;
    end
    chk("scan_done_cycle", 32'(cyc), 32'(t0 + 2 + N));
    tick();
    chk("busy_after_scan", 32'(busy), 32'd0);
    chk("events_drained", 32'(q.size()), 32'd0);
    q.delete();
  endtask

  initial begin
    int ev0, t0, n;
    bit seen;
    reset = 1'b0; frame_start = 1'b0; level_clear = 1'b0; coin_wr_en = 1'b0;
    sfx_ack = 1'b0; mario_x = '0; mario_y = '0;
    coin_wr_idx = '0; coin_wr_tx = '0; coin_wr_ty = '0;
    for (int i = 0; i < N; i++) begin mv[i] = 0; mcol[i] = 0; mtx[i] = 0; mty[i] = 0; end

    // frame vectors: mario position, expected collected mask, score, event count
    vecs[0] = '{x: 80,    y: 40,    col: 8'h08, score: 1, nev: 1};
    vecs[1] = '{x: 80,    y: 40,    col: 8'h08, score: 1, nev: 0};
    vecs[2] = '{x: 100,   y: 40,    col: 8'h28, score: 2, nev: 1};
    vecs[3] = '{x: 65530, y: 65530, col: 8'h28, score: 2, nev: 0};
    vecs[4] = '{x: 220,   y: 260,   col: 8'h7B, score: 6, nev: 4};
    vecs[5] = '{x: 0,     y: 0,     col: 8'hFB, score: 7, nev: 1};

    tick(); tick();
    chk("rst_collected", 32'(collected), 32'd0);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_coin_event", 32'(coin_event), 32'd0);
    chk("rst_scan_done", 32'(scan_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sfx_req", 32'(sfx_req), 32'd0);
    reset = 1'b1;
    tick();
    mon_en = 1'b1;

    wr(3, 2, 1); wr(5, 3, 1);
    wr(0, 5, 6); wr(1, 6, 6); wr(4, 5, 7); wr(6, 6, 7);
    wr(7, 0, 0);

    for (int v = 0; v < 6; v++) begin
      ev0 = ev_count;
      do_frame(vecs[v].x, vecs[v].y);
      chk($sformatf("v%0d_collected", v), 32'(collected), 32'(vecs[v].col));
      chk($sformatf("v%0d_score", v), 32'(score), 32'(vecs[v].score));
      chk($sformatf("v%0d_score_sat", v), 32'(score2),
          32'((vecs[v].score > 3) ? 3 : vecs[v].score));
      chk($sformatf("v%0d_events", v), 32'(ev_count - ev0), 32'(vecs[v].nev));
    end

    // seven sounds pending: sfx_req drops only after the seventh accepted ack
    chk("sfx_req_pending", 32'(sfx_req), 32'd1);
    sfx_ack = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk($sformatf("sfx_req_after_ack%0d", k), 32'(sfx_req), 32'(k < 7));
    end
    sfx_ack = 1'b0;

    // frame_start and table writes during a scan are dropped
    mario_x = 16'd0; mario_y = 16'd0;
    frame_start = 1'b1; tick(); frame_start = 1'b0; tick();
    frame_start = 1'b1; coin_wr_en = 1'b1; coin_wr_idx = 3'd2; coin_wr_tx = 8'd0; coin_wr_ty = 8'd0;
    tick();
    frame_start = 1'b0; coin_wr_en = 1'b0;
    chk("busy_mid_scan", 32'(busy), 32'd1);
    n = 0;
    while (busy && n < 20) begin tick(); n++; end
    chk("busy_wait_bounded", 32'(busy), 32'd0);
    tick();
    chk("no_queued_scan", 32'(busy), 32'd0);
    do_frame(0, 0);
    chk("dropped_write_collected", 32'(collected), 32'hFB);

    // level_clear aborts a scan at T+4
    mario_x = 16'd65530; mario_y = 16'd65530;
    t0 = cyc;
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    while (cyc < t0 + 4) tick();
    level_clear = 1'b1; tick(); level_clear = 1'b0;
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_collected", 32'(collected), 32'd0);
    chk("clr_score", 32'(score), 32'd0);
    chk("clr_score_sat", 32'(score2), 32'd0);
    seen = 1'b0;
    for (int k = 0; k < N + 4; k++) begin
      if (scan_done) seen = 1'b1;
      tick();
    end
    chk("clr_no_scan_done", 32'(seen), 32'd0);
    for (int i = 0; i < N; i++) mcol[i] = 1'b0;
    wr(2, 0, 0);
    do_frame(0, 0);
    chk("post_clr_collected", 32'(collected), 32'h84);
    chk("post_clr_score", 32'(score), 32'd2);
    chk("post_clr_sfx_req", 32'(sfx_req), 32'd1);

    // asynchronous reset in the middle of a scan
    mon_en = 1'b0;
    mario_x = 16'd220; mario_y = 16'd260;
    frame_start = 1'b1; tick(); frame_start = 1'b0; tick(); tick();
    reset = 1'b0;
    #1;
    chk("arst_collected", 32'(collected), 32'd0);
    chk("arst_score", 32'(score), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_coin_event", 32'(coin_event), 32'd0);
    chk("arst_event_idx", 32'(event_idx), 32'd0);
    chk("arst_sfx_req", 32'(sfx_req), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    for (int i = 0; i < N; i++) begin mv[i] = 1'b0; mcol[i] = 1'b0; end
    mon_en = 1'b1;
    ev0 = ev_count;
    do_frame(220, 260);
    do_frame(0, 0);
    chk("arst_table_invalid_events", 32'(ev_count - ev0), 32'd0);
    chk("arst_table_invalid_collected", 32'(collected), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
